apbspi_apb_master: RTL

Single-outstanding APB initiator that converts a simple command/response stream into APB3 transfers. It is the bus-side driver for the SPI peripheral's APB slave controller: the bench, the boot loader and any on-chip sequencer use it to program control/prescaler/IRQ registers and move TX/RX FIFO data. It adds address-alignment checking and a PREADY timeout, so a hung or absent slave cannot stall the requester.

---
 rtl/apbspi_apb_master_if.sv | 41 ++++
 rtl/apbspi_apb_master.sv | 135 +++++++++++++
 2 files changed

// File: rtl/apbspi_apb_master_if.sv
`default_nettype none
// =============================================================================
// Module   : apbspi_apb_master_if
// Brief    : Command/response stream plus APB3 bus bundle for apbspi_apb_master.
// Revision : 1.0  initial release
// =============================================================================
interface apbspi_apb_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;
    logic                  busy;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apbspi_apb_master.sv
`default_nettype none
// =============================================================================
// Module   : apbspi_apb_master
// Brief    : Single-outstanding APB3 initiator with alignment check and PREADY timeout.
// Revision : 1.0  initial release
// =============================================================================
module apbspi_apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  wire logic           pclk,
    input  wire logic           preset,
    apbspi_apb_master_if.master bus
);
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit               TO_EN    = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_ERR    = 2'd3
    } state_e;

    state_e                state_q,       state_d;
    logic [CNT_W-1:0]      wait_q,        wait_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [31:0]           pwdata_q,      pwdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [31:0]           rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_slverr_q,  rsp_slverr_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  cmd_ready;
    logic                  accept;

    assign cmd_ready = (state_q == S_IDLE) && !preset;
    assign accept    = bus.cmd_valid && cmd_ready;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                // Misaligned commands never touch the bus, so paddr/pwdata keep their old values.
                if (accept) begin
                    if (bus.cmd_addr[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_SETUP;
                        wait_d   = '0;
                        pwrite_d = bus.cmd_write;
                        paddr_d  = bus.cmd_addr;
                        pwdata_d = bus.cmd_write ? bus.cmd_wdata : 32'h0;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.pready) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = (pwrite_q || bus.pslverr) ? 32'h0 : bus.prdata;
                    rsp_slverr_d  = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (TO_EN && (wait_q == CNT_LAST)) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_ERR: begin
                state_d       = S_IDLE;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = 32'h0;
                rsp_slverr_d  = 1'b1;
                rsp_timeout_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign bus.penable     = (state_q == S_ACCESS);
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
`default_nettype wire
